// File: rtl/riscv_pkg.sv
// Shared definitions for the boot-time program loader: memory geometry,
// the loader FSM encoding and a helper for address width derivation.
package riscv_pkg;

  localparam int MEMORY_SIZE      = 1024;
  localparam int NB_COL           = 4;
  localparam int COL_WIDTH        = 8;
  localparam int LOADER_HDR_BYTES = 2;

  // Word address width for a memory of the given depth (at least 1 bit).
  function automatic int addr_width(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

  localparam int ADDR_WIDTH = addr_width(MEMORY_SIZE);

  typedef enum logic [2:0] {
    S_LEN_LO  = 3'd0,
    S_LEN_HI  = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CHK     = 3'd3,
    S_DONE    = 3'd4,
    S_ERROR   = 3'd5
  } loader_state_t;

endpackage

// File: rtl/prog_loader.sv
// Program loader: receives a length-prefixed, checksummed byte stream and
// writes it into an external byte-writable BRAM while holding the core in
// reset. Stream: LEN_LO, LEN_HI, 4*N payload bytes (LE per word), CHK.
//
// Handshake: a byte is transferred on a rising clk edge exactly when
// rx_valid and rx_ready are both 1; the sender may hold rx_valid low for any
// number of cycles, and rx_ready depends only on the current FSM state.
module prog_loader
  import riscv_pkg::*;
#(
  parameter int MEMORY_SIZE = riscv_pkg::MEMORY_SIZE,
  parameter int NB_COL      = riscv_pkg::NB_COL,
  parameter int COL_WIDTH   = riscv_pkg::COL_WIDTH,
  localparam int AW         = addr_width(MEMORY_SIZE)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_valid,
  output logic                        rx_ready,
  output logic [NB_COL-1:0]           mem_we,
  output logic [AW-1:0]               mem_addr,
  output logic [NB_COL*COL_WIDTH-1:0] mem_wdata,
  output logic                        core_reset_o,
  output logic                        load_done_o,
  output logic                        load_error_o,
  output logic [2:0]                  fsm_state
);

  loader_state_t state, state_next;

  logic [7:0]    len_lo;
  logic [15:0]   len;
  logic [15:0]   len_rx;
  logic [AW-1:0] word_cnt;
  logic [1:0]    byte_cnt;
  logic [7:0]    sum;
  logic          xfer;
  logic          len_bad;
  logic          last_byte;
  logic [7:0]    chk_total;

  assign xfer      = rx_valid && rx_ready;
  assign len_rx    = {rx_data, len_lo};
  assign len_bad   = (len_rx == 16'd0) || (int'(len_rx) > MEMORY_SIZE);
  assign last_byte = (byte_cnt == 2'd3) && (int'(word_cnt) == int'(len) - 1);
  assign chk_total = sum + rx_data;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_LEN_LO;
    else       state <= state_next;
  end

  // Next-state logic; terminal states are left only through reset.
  always_comb begin
    state_next = state;
    case (state)
      S_LEN_LO:  if (xfer) state_next = S_LEN_HI;
      S_LEN_HI:  if (xfer) state_next = len_bad ? S_ERROR : S_PAYLOAD;
      S_PAYLOAD: if (xfer && last_byte) state_next = S_CHK;
      S_CHK:     if (xfer) state_next = (chk_total == 8'd0) ? S_DONE : S_ERROR;
      S_DONE:    state_next = S_DONE;
      S_ERROR:   state_next = S_ERROR;
      default:   state_next = S_ERROR;
    endcase
  end

  // State-decoded outputs; core reset drops in the same cycle done rises.
  always_comb begin
    rx_ready     = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                   (state == S_PAYLOAD) || (state == S_CHK);
    core_reset_o = (state != S_DONE);
    load_done_o  = (state == S_DONE);
    load_error_o = (state == S_ERROR);
    fsm_state    = state;
  end

  // Datapath: length capture, counters, running sum and registered BRAM port.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_lo    <= '0;
      len       <= '0;
      word_cnt  <= '0;
      byte_cnt  <= '0;
      sum       <= '0;
      mem_we    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= '0;
      case (state)
        S_LEN_LO: begin
          sum <= '0;
          if (xfer) len_lo <= rx_data;
        end
        S_LEN_HI: begin
          if (xfer) begin
            len      <= len_rx;
            word_cnt <= '0;
            byte_cnt <= '0;
          end
        end
        S_PAYLOAD: begin
          if (xfer) begin
            mem_we    <= NB_COL'(1) << byte_cnt;
            mem_addr  <= word_cnt;
            mem_wdata <= {NB_COL{COL_WIDTH'(rx_data)}};
            sum       <= sum + rx_data;
            byte_cnt  <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) word_cnt <= word_cnt + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: randomized byte streams against a queue of expected
// BRAM writes derived from the stream format, plus status checks per scenario.
`timescale 1ns/1ps
module tb_prog_loader;
  import riscv_pkg::*;

  localparam int AW = 10;
  localparam int W  = AW + 4 + 32;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [3:0]  mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        core_reset_o;
  logic        load_done_o;
  logic        load_error_o;
  logic [2:0]  fsm_state;

  int checks = 0;
  int errors = 0;
  int idle_pct = 0;
  int writes_seen = 0;

  logic [W-1:0] exp_q[$];
  logic [7:0]   payload[4096];
  logic [31:0]  mem_obs[1024];

  prog_loader dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .core_reset_o(core_reset_o),
    .load_done_o(load_done_o), .load_error_o(load_error_o),
    .fsm_state(fsm_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #800us;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every observed write must match the head of the expected queue.
  always @(negedge clk) begin
    if (mem_we !== 4'b0000) begin
      logic [W-1:0] got;
      logic [W-1:0] exp;
      got = {mem_addr, mem_we, mem_wdata};
      writes_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0d we=%b data=%h, required no write",
                 mem_addr, mem_we, mem_wdata);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL write: got addr=%0d we=%b data=%h, required addr=%0d we=%b data=%h",
                   mem_addr, mem_we, mem_wdata, exp[W-1 -: AW], exp[35:32], exp[31:0]);
        end
      end
      for (int c = 0; c < 4; c++)
        if (mem_we[c] === 1'b1) mem_obs[mem_addr][c*8 +: 8] = mem_wdata[c*8 +: 8];
    end
  end

  // Driver tasks.
  task automatic do_reset();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    reset    = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    writes_seen = 0;
    for (int i = 0; i < 1024; i++) mem_obs[i] = 32'h0;
  endtask

  // One byte with optional random idle cycles in front of it.
  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    while (($urandom_range(0, 99) < idle_pct) && (guard < 40)) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      @(posedge clk);
      #1;
      guard++;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  // Full image of n words from payload[]; checksum makes the byte sum zero
  // mod 256 when good=1, otherwise bad_chk is sent as given.
  task automatic send_image(input int n, input bit good, input logic [7:0] bad_chk);
    logic [7:0] s;
    logic [15:0] n16;
    s = 8'h00;
    n16 = 16'(n);
    send_byte(n16[7:0]);
    send_byte(n16[15:8]);
    for (int i = 0; i < 4 * n; i++) begin
      exp_q.push_back({AW'(i / 4), 4'(1 << (i % 4)), {4{payload[i]}}});
      s = s + payload[i];
      send_byte(payload[i]);
    end
    send_byte(good ? (8'h00 - s) : bad_chk);
    @(negedge clk);
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < 4 * n; i++) payload[i] = 8'($urandom);
  endtask

  // Scenarios.
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready: got %b required 1", rx_ready); end
    checks++; if (mem_we !== 4'b0) begin errors++; $display("FAIL reset_mem_we: got %b required 0000", mem_we); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr: got %0d required 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h required 0", mem_wdata); end
    checks++; if (core_reset_o !== 1'b1) begin errors++; $display("FAIL reset_core_reset: got %b required 1", core_reset_o); end
    checks++; if (load_done_o !== 1'b0 || load_error_o !== 1'b0) begin errors++; $display("FAIL reset_status: got done=%b err=%b required 0 0", load_done_o, load_error_o); end
    checks++; if (fsm_state !== S_LEN_LO) begin errors++; $display("FAIL reset_state: got %0d required %0d", fsm_state, S_LEN_LO); end
  endtask

  task automatic test_example(input bit good);
    logic [7:0] ex[8];
    ex = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    do_reset();
    for (int i = 0; i < 8; i++) payload[i] = ex[i];
    send_image(2, good, 8'h00);
    checks++; if (writes_seen != 8) begin errors++; $display("FAIL example_write_count: got %0d required 8", writes_seen); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL example_missing_writes: got %0d pending required 0", exp_q.size()); end
    checks++; if (load_done_o !== good || load_error_o !== !good) begin errors++; $display("FAIL example_status: got done=%b err=%b required done=%b", load_done_o, load_error_o, good); end
    checks++; if (core_reset_o !== !good) begin errors++; $display("FAIL example_core_reset: got %b required %b", core_reset_o, !good); end
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL example_rx_ready: got %b required 0", rx_ready); end
    // Further bytes after a terminal state must not produce writes.
    for (int i = 0; i < 6; i++) send_byte(8'($urandom));
    @(negedge clk);
    checks++; if (load_done_o !== good || load_error_o !== !good) begin errors++; $display("FAIL example_sticky: got done=%b err=%b required done=%b", load_done_o, load_error_o, good); end
  endtask

  task automatic test_bad_len(input logic [15:0] n);
    do_reset();
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    @(negedge clk);
    checks++; if (load_error_o !== 1'b1) begin errors++; $display("FAIL bad_len_error len=%h: got %b required 1", n, load_error_o); end
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL bad_len_rx_ready len=%h: got %b required 0", n, rx_ready); end
    checks++; if (core_reset_o !== 1'b1 || load_done_o !== 1'b0) begin errors++; $display("FAIL bad_len_core len=%h: got core=%b done=%b required 1 0", n, core_reset_o, load_done_o); end
    for (int i = 0; i < 8; i++) send_byte(8'($urandom));
    @(negedge clk);
    checks++; if (writes_seen != 0) begin errors++; $display("FAIL bad_len_writes len=%h: got %0d required 0", n, writes_seen); end
  endtask

  task automatic test_full_memory();
    int bad;
    do_reset();
    fill_random(1024);
    send_image(1024, 1'b1, 8'h00);
    checks++; if (writes_seen != 4096) begin errors++; $display("FAIL full_write_count: got %0d required 4096", writes_seen); end
    checks++; if (load_done_o !== 1'b1 || core_reset_o !== 1'b0) begin errors++; $display("FAIL full_status: got done=%b core=%b required 1 0", load_done_o, core_reset_o); end
    bad = 0;
    for (int w = 0; w < 1024; w++) begin
      logic [31:0] want;
      want = {payload[4*w+3], payload[4*w+2], payload[4*w+1], payload[4*w]};
      checks++;
      if (mem_obs[w] !== want) begin
        errors++;
        if (bad < 4) $display("FAIL full_mem word %0d: got %h required %h", w, mem_obs[w], want);
        bad++;
      end
    end
  endtask

  task automatic test_idle_gaps();
    for (int rep = 0; rep < 3; rep++) begin
      int n;
      n = $urandom_range(1, 6);
      do_reset();
      fill_random(n);
      idle_pct = 70;
      send_image(n, 1'b1, 8'h00);
      idle_pct = 0;
      checks++; if (writes_seen != 4 * n || exp_q.size() != 0) begin errors++; $display("FAIL idle_writes n=%0d: got %0d pending %0d required %0d pending 0", n, writes_seen, exp_q.size(), 4 * n); end
      checks++; if (load_done_o !== 1'b1) begin errors++; $display("FAIL idle_done n=%0d: got %b required 1", n, load_done_o); end
    end
  endtask

  task automatic test_reset_mid_payload();
    do_reset();
    fill_random(2);
    send_byte(8'h02);
    send_byte(8'h00);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({AW'(i / 4), 4'(1 << (i % 4)), {4{payload[i]}}});
      send_byte(payload[i]);
    end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (writes_seen != 5 || exp_q.size() != 0) begin errors++; $display("FAIL midreset_partial: got %0d writes required 5", writes_seen); end
    checks++; if (fsm_state !== S_LEN_LO || core_reset_o !== 1'b1) begin errors++; $display("FAIL midreset_state: got state=%0d core=%b required %0d 1", fsm_state, core_reset_o, S_LEN_LO); end
    writes_seen = 0;
    fill_random(1);
    send_image(1, 1'b1, 8'h00);
    checks++; if (writes_seen != 4 || exp_q.size() != 0) begin errors++; $display("FAIL midreset_new_writes: got %0d required 4", writes_seen); end
    checks++; if (load_done_o !== 1'b1 || core_reset_o !== 1'b0) begin errors++; $display("FAIL midreset_done: got done=%b core=%b required 1 0", load_done_o, core_reset_o); end
  endtask

  // Sequencer and report.
  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    test_reset();
    test_example(1'b1);
    test_example(1'b0);
    test_bad_len(16'h0000);
    test_bad_len(16'h0401);
    test_idle_gaps();
    test_reset_mid_payload();
    test_full_memory();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL final_queue: got %0d pending required 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
